// File: rtl/seg7_bcd_feeder_pkg.sv
// Shared definitions for seg7_bcd_feeder: FSM state encoding, register
// offsets, status bit positions and the 10^n helper.
package seg7_bcd_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned REG_VALUE  = 0;
  localparam int unsigned REG_RESULT = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_OVF  = 1;

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_bcd_feeder_bcd_add3_stage.sv
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3
// so the following left shift carries correctly into the next digit.
module bcd_add3_stage #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic [NDIGITS*4-1:0] bcd_in,
  output logic [NDIGITS*4-1:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (bcd_in[i*4 +: 4] >= 4'd5) begin
        bcd_out[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/seg7_bcd_feeder.sv
// Binary-to-BCD bus slave that forwards each result as a one-beat write to
// the 7-segment driver. Optional SEG7_BCD_SATURATE_EN clamps overflow to 9s.
module seg7_bcd_feeder
  import seg7_bcd_feeder_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h20,
  parameter logic [31:0] SEG_BASE = 32'h10,
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned NBITS    = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        seg_enable,
  output logic        seg_rw,
  output logic [31:0] seg_addr,
  output logic [31:0] seg_data
);

  localparam int unsigned BW = NDIGITS * 4;
  localparam int unsigned CW = $clog2(NBITS + 1);

  state_t            state, state_nx;
  logic [NBITS-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NBITS-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [BW-1:0]     result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              seg_en_d;
  logic [BW-1:0]     seg_bcd_d;

  logic [BW-1:0]     bcd_adj, bcd_shift, bcd_final;
  logic              start;
  logic [NBITS-1:0]  start_val;
  logic              wr_value;
  logic [NBITS-1:0]  wdata;
  logic              busy;
  logic              rd_status, rd_result;
  logic [31:0]       rdata;

  assign wdata    = data[NBITS-1:0];
  assign wr_value = enable && rw && (addr == BASE + 32'(REG_VALUE));
  assign busy     = (state != IDLE) || pend_vld_q;

  bcd_add3_stage #(.NDIGITS(NDIGITS)) u_add3 (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_adj)
  );

  assign bcd_shift = {bcd_adj[BW-2:0], bin_q[NBITS-1]};

`ifdef SEG7_BCD_SATURATE_EN
  assign bcd_final = ovf_q ? {NDIGITS{4'h9}} : bcd_shift;
`else
  assign bcd_final = bcd_shift;
`endif

  always_comb begin
    state_nx   = state;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    seg_en_d   = 1'b0;
    seg_bcd_d  = '0;
    start      = 1'b0;
    start_val  = wdata;

    case (state)
      IDLE: begin
        if (wr_value) begin
          start     = 1'b1;
          start_val = wdata;
        end
      end
      SHIFT: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - CW'(1);
        if (wr_value) begin
          pend_d     = wdata;
          pend_vld_d = 1'b1;
        end
        if (cnt_q == CW'(1)) begin
          state_nx  = WRITE;
          seg_en_d  = 1'b1;
          seg_bcd_d = bcd_final;
          result_d  = bcd_final;
        end
      end
      WRITE: begin
        // A pending value wins; a write landing now with nothing pending
        // starts directly, which is the same as pending-then-consume.
        if (pend_vld_q) begin
          start      = 1'b1;
          start_val  = pend_q;
          pend_vld_d = 1'b0;
          if (wr_value) begin
            pend_d     = wdata;
            pend_vld_d = 1'b1;
          end
        end else if (wr_value) begin
          start     = 1'b1;
          start_val = wdata;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start) begin
      state_nx = SHIFT;
      bin_d    = start_val;
      bcd_d    = '0;
      cnt_d    = CW'(NBITS);
      ovf_d    = (32'(start_val) >= pow10(NDIGITS));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      seg_enable <= 1'b0;
      seg_rw     <= 1'b0;
      seg_addr   <= '0;
      seg_data   <= '0;
    end else begin
      state      <= state_nx;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      seg_enable <= seg_en_d;
      seg_rw     <= seg_en_d;
      seg_addr   <= seg_en_d ? SEG_BASE : '0;
      seg_data   <= 32'(seg_bcd_d);
    end
  end

  assign rd_status = enable && !rw && (addr == BASE + 32'(REG_VALUE));
  assign rd_result = enable && !rw && (addr == BASE + 32'(REG_RESULT));

  always_comb begin
    rdata = '0;
    if (rd_status) begin
      rdata[STAT_BUSY] = busy;
      rdata[STAT_OVF]  = ovf_q;
    end else begin
      rdata = 32'(result_q);
    end
  end

  assign data = (rd_status || rd_result) ? rdata : 'z;

endmodule

// File: doc/seg7_bcd_feeder.md
# seg7_bcd_feeder

Bus slave that accepts a binary value from the CPU, converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, then issues one bus write of the result to the 7-segment driver's data register. It sits directly upstream of the 7-segment driver, so software can display decimal numbers without doing its own division. It also acts as a one-beat bus master toward that driver.

## Interface
Parameters:
- BASE, 32'h20, slave base address; occupies BASE and BASE+1
- SEG_BASE, 32'h10, address of the 7-segment driver's digit register
- NDIGITS, 4, number of BCD digits produced
- NBITS, 14, width of the accepted binary value

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock; all state changes on posedge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  slave bus strobe
- rw  in  1  1 = write, 0 = read
- addr  in  32  slave address
- data  inout  32  slave data; driven only during a valid read, else high-Z
- seg_enable  out  1  master strobe to the 7-segment driver
- seg_rw  out  1  master direction; always 1 when seg_enable = 1
- seg_addr  out  32  master address
- seg_data  out  32  master write data; BCD in [NDIGITS*4-1:0], upper bits 0

## Operation
- Register map:
  - BASE write: value = data[NBITS-1:0].
  - BASE read: {30'b0, ovf, busy}.
  - BASE+1 read: last completed BCD result, zero-extended.
  - Writes to BASE+1 are ignored.
- FSM states: IDLE, SHIFT, WRITE.
- IDLE:
  - On a write to BASE, load the shift register with the value, clear the BCD accumulator, set bit_cnt = NBITS, and go to SHIFT.
  - Compute ovf = (value >= 10^NDIGITS) at this point.
- SHIFT:
  - Each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 and bit_cnt decrements.
  - When bit_cnt reaches 1, the final shift happens and the FSM goes to WRITE.
  - Carries out of the top nibble are discarded.
- WRITE:
  - seg_enable = 1, seg_rw = 1, seg_addr = SEG_BASE, seg_data = result, for exactly one cycle.
  - The result register updates in this same cycle.
  - Next state is SHIFT if a pending value exists (the pending value is consumed), else IDLE.
- busy = (state != IDLE) or pending valid.
- Write to BASE while busy:
  - The value goes to a one-deep pending register.
  - A later write overwrites it (last-writer-wins). No stall and no error.
- Write arriving in the WRITE cycle with no pending value: it becomes pending and starts in the next cycle.
- Reads have no side effects. data is driven combinationally while enable=1, rw=0 and addr is in range.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, pending cleared, result = 0, ovf = 0.
  - seg_enable = 0, seg_rw = 0, seg_addr = 0, seg_data = 0.
  - Reset mid-conversion aborts it; no master write is issued.
- Latency: write accepted at edge 0, SHIFT during cycles 1..NBITS, seg_enable high in cycle NBITS+1.
- seg_* outputs are registered. They are 0 (not held) whenever seg_enable = 0.
- The downstream driver samples on negedge clk inside the WRITE cycle. No backpressure exists; the write is fire-and-forget.
- Minimum spacing between master writes is NBITS+1 cycles.

## Configuration
- SEG7_BCD_SATURATE_EN:
  - Defined: when ovf = 1, the result is forced to all nibbles 4'h9 ("9999").
  - Undefined: the result is value mod 10^NDIGITS (natural truncation).
- The ovf status bit is computed and readable in both builds.

## Structure
- Shared package holds:
  - state encoding (IDLE/SHIFT/WRITE)
  - register offsets (REG_VALUE = 0, REG_RESULT = 1)
  - status bit indices (BUSY = 0, OVF = 1)
  - the function computing 10^NDIGITS
- One sub-module, bcd_add3_stage: combinational. Takes NDIGITS*4 BCD bits and applies add-3 to each nibble >= 5. Instantiated once and used each SHIFT cycle.

## Test plan
- Write 1234 to BASE → seg_enable pulse at cycle 15 with seg_addr = 0x10, seg_data = 0x00001234. BASE+1 then reads 0x1234; status reads 0.
- Write 0, then 9999 → master writes 0x0000, then 0x9999. ovf stays 0.
- Write 12345 → SATURATE_EN build: seg_data = 0x9999. Other build: 0x2345. Both builds: status = 0b10 after completion.
- Write 11, then 22 and 33 during the conversion → exactly two master writes (0x0011, then 0x0033). busy clears after the second.
- Assert reset_n low at SHIFT cycle 7 → no seg_enable pulse, all outputs 0. The next write of 42 yields 0x0042.
- Read BASE during a conversion → 0x1. Reads outside BASE..BASE+1 → data is high-Z.
